// File: rtl/llc_set_writer_pkg.sv
// +----------------------------------------------------------------------------+
// | llc_set_writer_pkg: shared LLC cache types and set-writer state encoding.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif

package llc_set_writer_pkg;

  localparam int LLC_WAYS     = `LLC_WAYS;
  localparam int LLC_SET_BITS = 8;
  localparam int LLC_TAG_BITS = 12;
  localparam int LINE_BITS    = 64;
  localparam int WAY_BITS     = (LLC_WAYS > 1) ? $clog2(LLC_WAYS) : 1;

  typedef logic [LLC_SET_BITS-1:0]              llc_set_t;
  typedef logic [WAY_BITS-1:0]                  llc_way_t;
  typedef logic [LLC_TAG_BITS-1:0]              llc_tag_t;
  typedef logic [LLC_TAG_BITS+LLC_SET_BITS-1:0] line_addr_t;
  typedef logic [LINE_BITS-1:0]                 line_t;
  typedef logic [2:0]                           llc_state_t;
  typedef logic [LLC_WAYS-1:0]                  sharers_t;
  typedef logic [WAY_BITS-1:0]                  owner_t;
  typedef logic [1:0]                           hprot_t;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_SCAN    = 3'd1,
    WR_MEM_REQ = 3'd2,
    WR_SRAM_WR = 3'd3,
    WR_DONE    = 3'd4
  } llc_set_writer_state_t;

endpackage

`default_nettype wire

// File: rtl/llc_way_prio_enc.sv
// +----------------------------------------------------------------------------+
// | llc_way_prio_enc: lowest-set-bit encoder over a way mask, with valid flag. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module llc_way_prio_enc #(
  parameter int WAYS = 16,
  parameter int IW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0] req_i,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  // Walk downward so the lowest requesting way is the final assignment.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/llc_set_writer.sv
// +----------------------------------------------------------------------------+
// | llc_set_writer: commits one LLC set's way buffers to SRAM, evicting dirty  |
// | lines to memory first. LLC_SET_WRITER_SKIP_EN selects the skipping scan.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module llc_set_writer
  import llc_set_writer_pkg::*;
#(
  parameter int WAYS = LLC_WAYS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_state,
  input  logic       start,
  input  llc_set_t   set_in,
  input  logic [WAYS-1:0] wr_mask,
  input  logic [WAYS-1:0] wb_mask,
  input  line_t      lines_buf      [WAYS],
  input  llc_tag_t   tags_buf       [WAYS],
  input  llc_state_t states_buf     [WAYS],
  input  sharers_t   sharers_buf    [WAYS],
  input  owner_t     owners_buf     [WAYS],
  input  hprot_t     hprots_buf     [WAYS],
  input  logic       dirty_bits_buf [WAYS],
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output llc_set_t   wr_set,
  output llc_way_t   wr_way,
  output line_t      wr_data_line,
  output llc_tag_t   wr_data_tag,
  output llc_state_t wr_data_state,
  output sharers_t   wr_data_sharers,
  output owner_t     wr_data_owner,
  output hprot_t     wr_data_hprot,
  output logic       wr_data_dirty_bit,
  output logic       llc_mem_req_valid,
  input  logic       llc_mem_req_ready,
  output line_addr_t llc_mem_req_addr,
  output line_t      llc_mem_req_line,
  output hprot_t     llc_mem_req_hprot,
  output logic       llc_mem_req_hwrite
);

  localparam int            IW       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WAYS - 1);

  llc_set_writer_state_t state_q;
  logic [IW-1:0]         idx_q;
  logic [WAYS-1:0]       pend_q;
  logic [WAYS-1:0]       wb_q;
  llc_set_t              set_q;
  logic                  evicted_q;

  logic [IW-1:0]         w_scan_idx;
  logic                  w_scan_hit;
  logic                  w_wr;
  logic                  w_mreq;

`ifdef LLC_SET_WRITER_SKIP_EN
  logic [IW-1:0] w_enc_idx;
  logic          w_enc_valid;

  llc_way_prio_enc #(.WAYS(WAYS), .IW(IW)) u_prio_enc (
    .req_i   (pend_q),
    .idx_o   (w_enc_idx),
    .valid_o (w_enc_valid)
  );

  assign w_scan_idx = w_enc_idx;
  assign w_scan_hit = w_enc_valid;
`else
  assign w_scan_idx = idx_q;
  assign w_scan_hit = pend_q[idx_q];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WR_IDLE;
      idx_q     <= '0;
      pend_q    <= '0;
      wb_q      <= '0;
      set_q     <= '0;
      evicted_q <= 1'b0;
    end else if (rst_state) begin
      state_q   <= WR_IDLE;
      idx_q     <= '0;
      pend_q    <= '0;
      evicted_q <= 1'b0;
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (start) begin
            set_q   <= set_in;
            pend_q  <= wr_mask | wb_mask;
            wb_q    <= wb_mask;
            idx_q   <= '0;
            state_q <= WR_SCAN;
          end
        end
        WR_SCAN: begin
          if (w_scan_hit) begin
            idx_q   <= w_scan_idx;
            state_q <= (wb_q[w_scan_idx] & dirty_bits_buf[w_scan_idx]) ? WR_MEM_REQ : WR_SRAM_WR;
          end else begin
`ifdef LLC_SET_WRITER_SKIP_EN
            state_q <= WR_DONE;
`else
            if (idx_q == LAST_IDX) state_q <= WR_DONE;
            else                   idx_q   <= idx_q + 1'b1;
`endif
          end
        end
        WR_MEM_REQ: begin
          if (llc_mem_req_ready) begin
            evicted_q <= 1'b1;
            state_q   <= WR_SRAM_WR;
          end
        end
        WR_SRAM_WR: begin
          pend_q[idx_q] <= 1'b0;
          evicted_q     <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q <= WR_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= WR_SCAN;
          end
        end
        WR_DONE: state_q <= WR_IDLE;
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign w_wr   = (state_q == WR_SRAM_WR);
  assign w_mreq = (state_q == WR_MEM_REQ);

  assign busy  = (state_q != WR_IDLE);
  assign done  = (state_q == WR_DONE);
  assign wr_en = w_wr;

  // Data ports are gated by state so every output is zero while idle or in reset.
  assign wr_set            = w_wr ? set_q                  : '0;
  assign wr_way            = w_wr ? llc_way_t'(idx_q)      : '0;
  assign wr_data_line      = w_wr ? lines_buf[idx_q]       : '0;
  assign wr_data_tag       = w_wr ? tags_buf[idx_q]        : '0;
  assign wr_data_state     = w_wr ? states_buf[idx_q]      : '0;
  assign wr_data_sharers   = w_wr ? sharers_buf[idx_q]     : '0;
  assign wr_data_owner     = w_wr ? owners_buf[idx_q]      : '0;
  assign wr_data_hprot     = w_wr ? hprots_buf[idx_q]      : '0;
  assign wr_data_dirty_bit = w_wr & dirty_bits_buf[idx_q] & ~evicted_q;

  assign llc_mem_req_valid  = w_mreq;
  assign llc_mem_req_hwrite = w_mreq;
  assign llc_mem_req_addr   = w_mreq ? {tags_buf[idx_q], set_q} : '0;
  assign llc_mem_req_line   = w_mreq ? lines_buf[idx_q]         : '0;
  assign llc_mem_req_hprot  = w_mreq ? hprots_buf[idx_q]        : '0;

endmodule

`default_nettype wire

// File: doc/llc_set_writer.md
# llc_set_writer

Write-back engine for one LLC set. Once a set's per-way buffers have been loaded and modified, the controller hands them to this block. For every selected way it first issues a dirty-line write to memory when eviction is requested, then commits that way's line, tag, state, sharers, owner, hprot and dirty bit back into the LLC SRAM arrays. It sits between the set buffers and the SRAM write ports / `llc_mem_req` channel, the opposite direction of the set-load path.

## Interface
- `WAYS`, default `` `LLC_WAYS `` (16): number of ways and mask width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rst_state` in 1: synchronous abort to IDLE.
- `start` in 1: begin write-back; accepted only in IDLE.
- `set_in` in `llc_set_t`: set index, latched on accepted start.
- `wr_mask` in WAYS: ways to commit to SRAM, latched on start.
- `wb_mask` in WAYS: ways to evict to memory if dirty, latched on start.
- `lines_buf`, `tags_buf`, `states_buf`, `sharers_buf`, `owners_buf`, `hprots_buf`, `dirty_bits_buf` in `[WAYS]` of `line_t` / `llc_tag_t` / `llc_state_t` / `sharers_t` / `owner_t` / `hprot_t` / `logic`: set buffers. Must be held stable while `busy`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `wr_en` out 1: SRAM write strobe, one cycle per committed way.
- `wr_set` out `llc_set_t`: SRAM set index.
- `wr_way` out `llc_way_t`: SRAM way index.
- `wr_data_line`, `wr_data_tag`, `wr_data_state`, `wr_data_sharers`, `wr_data_owner`, `wr_data_hprot`, `wr_data_dirty_bit` out: SRAM write data.
- `llc_mem_req_valid` out 1: memory write request valid.
- `llc_mem_req_ready` in 1: memory write request ready.
- `llc_mem_req_addr` out `line_addr_t`: `{tags_buf[way], set}`.
- `llc_mem_req_line` out `line_t`: line to write.
- `llc_mem_req_hprot` out `hprot_t`: hprot of the line.
- `llc_mem_req_hwrite` out 1: always 1 while valid.

## Operation
- States: IDLE, SCAN, MEM_REQ, SRAM_WR, DONE.
- IDLE: on `start`, latch `set_in` and `pend = wr_mask | wb_mask`; set `idx = 0`; go to SCAN.
- SCAN, linear: if `pend[idx]`, go to MEM_REQ when `wb_mask[idx] & dirty_bits_buf[idx]`, else to SRAM_WR. Otherwise advance `idx`, or go to DONE when `idx == WAYS-1`.
- MEM_REQ: `valid` high with address, line and hprot of `idx`. Hold until `valid & ready`, then go to SRAM_WR with the `evicted` flag set.
- SRAM_WR: `wr_en = 1`. Data is the buffers at `idx`, except `wr_data_dirty_bit = dirty_bits_buf[idx] & ~evicted`. Clear `pend[idx]` and `evicted`. Go to SCAN at `idx+1`, or to DONE if `idx == WAYS-1`.
- A way in `wb_mask` only (clean or dirty) is still written to SRAM, so the dirty bit is cleared.
- DONE: `done = 1` for one cycle, then IDLE.
- `start` while busy is ignored; no queueing.
- `idx` is `$clog2(WAYS)` bits and never wraps; the scan terminates at `WAYS-1`.

## Timing
- All outputs reset to 0 (`rst` low): state IDLE, `pend = 0`, `idx = 0`.
- `wr_en`, `valid`, `busy` and `done` are decoded from registered state only.
- Data outputs are muxed from stable buffers by the registered `idx`.
- `valid` never depends combinationally on `ready`. Once raised it stays high until the handshake, except on `rst_state`.
- `rst_state` wins over all other events. The next state is IDLE with no `done` pulse. `valid` drops even mid-request; the owner guarantees the memory side is also reset.
- Linear latency, start at cycle T: SCAN way 0 at T+1. Each selected way costs 1 extra cycle, plus MEM_REQ cycles (at least 1). Empty masks give `done` at T+17 with WAYS=16.

## Configuration
- `LLC_SET_WRITER_SKIP_EN` defined: SCAN uses a priority encoder on `pend`. `idx` becomes the lowest set bit in one cycle; an empty `pend` goes to DONE. Empty masks give `done` at T+2.
- Not defined: linear one-way-per-cycle scan as above.
- Functional results (write order, data, requests) are identical either way; only the cycle count differs.

## Structure
- `llc_set_writer_state_t` enum goes in the shared cache types package, alongside `llc_set_t`, `llc_way_t`, `line_addr_t` and `hprot_t`.
- One sub-module is natural: `llc_way_prio_enc` (WAYS-bit lowest-set-bit encoder with valid output), instantiated only under the macro.

## Test plan
- Masks 0, linear: `start` at T → no `wr_en`, no `valid`, `done` at T+17; with macro, `done` at T+2.
- `wr_mask=0x0001`, linear: `wr_en` at T+2 with `wr_way=0` and `wr_set=set_in`, `done` at T+18. With macro: `wr_en` at T+2, `done` at T+4.
- `wb_mask=0x8000`, `dirty_bits_buf[15]=1`, `tags_buf[15]=0x5A`, `ready` low 3 cycles → `valid` held 4 cycles with `addr={0x5A,set}` and `hwrite=1`. Then `wr_en` for way 15 with `wr_data_dirty_bit=0`.
- `wb_mask=0x0004`, way 2 clean → no memory request; `wr_en` way 2 with dirty 0.
- `rst_state` asserted during MEM_REQ → next cycle IDLE, `valid=0`, `busy=0`, no `done`. A second `start` while busy is ignored.
- `rst` pulled low mid-SRAM_WR → all outputs 0 asynchronously; a fresh `start` after release completes normally.
